// File: rtl/pair_judge.sv
// rtl/pair_judge.sv - turn/match controller for a 16-card memory game; optional turn timeout via TURN_TIMEOUT_EN
module pair_judge #(
    parameter int N_PAIRS       = 8,
    parameter int REVEAL_CYCLES = 50000000,
    parameter int CNT_W         = 26
`ifdef TURN_TIMEOUT_EN
    ,
    parameter int TURN_CYCLES   = 500000000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       select,
    input  logic [3:0] cursor,
    input  logic [3:0] card_label,
    input  logic       card_hidden,
    output logic       reveal,
    output logic [3:0] reveal_idx,
    output logic       hide,
    output logic       par,
    output logic [3:0] idx_a,
    output logic [3:0] idx_b,
    output logic       player,
    output logic [3:0] score0,
    output logic [3:0] score1,
    output logic       busy,
    output logic       finish,
    output logic [1:0] winner
`ifdef TURN_TIMEOUT_EN
    ,
    output logic       timeout
`endif
);

    localparam logic [2:0] S_FIRST   = 3'd0;
    localparam logic [2:0] S_SECOND  = 3'd1;
    localparam logic [2:0] S_SHOW    = 3'd2;
    localparam logic [2:0] S_RESOLVE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam int PL_W = $clog2(N_PAIRS + 1);

    logic [2:0]       state_q, state_d;
    logic [3:0]       idx_a_q, idx_a_d, idx_b_q, idx_b_d, reveal_idx_q, reveal_idx_d;
    logic [3:0]       label_a_q, label_a_d, label_b_q, label_b_d;
    logic [3:0]       score0_q, score0_d, score1_q, score1_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [PL_W-1:0]  pairs_left_q, pairs_left_d;
    logic             reveal_q, reveal_d, hide_q, hide_d, par_q, par_d;
    logic             player_q, player_d, busy_q, busy_d, finish_q, finish_d;
    logic [1:0]       winner_q, winner_d;

`ifdef TURN_TIMEOUT_EN
    localparam int TO_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam logic [TO_W-1:0] TMO_RELOAD = TO_W'(TURN_CYCLES - 1);
    logic [TO_W-1:0] tmo_q, tmo_d;
    logic            timeout_q, timeout_d;
`endif

    always_comb begin
        state_d      = state_q;
        idx_a_d      = idx_a_q;
        idx_b_d      = idx_b_q;
        reveal_idx_d = reveal_idx_q;
        label_a_d    = label_a_q;
        label_b_d    = label_b_q;
        score0_d     = score0_q;
        score1_d     = score1_q;
        timer_d      = timer_q;
        pairs_left_d = pairs_left_q;
        player_d     = player_q;
        reveal_d     = 1'b0;
        hide_d       = 1'b0;
        par_d        = 1'b0;

        case (state_q)
            S_FIRST: begin
                if (select && card_hidden) begin
                    idx_a_d      = cursor;
                    label_a_d    = card_label;
                    reveal_d     = 1'b1;
                    reveal_idx_d = cursor;
                    state_d      = S_SECOND;
                end
            end
            S_SECOND: begin
                if (select && card_hidden && (cursor != idx_a_q)) begin
                    idx_b_d      = cursor;
                    label_b_d    = card_label;
                    reveal_d     = 1'b1;
                    reveal_idx_d = cursor;
                    timer_d      = CNT_W'(REVEAL_CYCLES - 1);
                    state_d      = S_SHOW;
                end
            end
            S_SHOW: begin
                if (timer_q == '0) state_d = S_RESOLVE;
                else               timer_d = timer_q - CNT_W'(1);
            end
            S_RESOLVE: begin
                if (label_a_q == label_b_q) begin
                    par_d = 1'b1;
                    if (!player_q) score0_d = (score0_q == 4'd15) ? score0_q : score0_q + 4'd1;
                    else           score1_d = (score1_q == 4'd15) ? score1_q : score1_q + 4'd1;
                    pairs_left_d = pairs_left_q - PL_W'(1);
                    state_d      = (pairs_left_q == PL_W'(1)) ? S_DONE : S_FIRST;
                end else begin
                    hide_d   = 1'b1;
                    player_d = ~player_q;
                    state_d  = S_FIRST;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_FIRST;
        endcase

`ifdef TURN_TIMEOUT_EN
        // Idle turn: reload on accepted select, else count down and forfeit on expiry.
        timeout_d = 1'b0;
        tmo_d     = tmo_q;
        if (state_q == S_FIRST || state_q == S_SECOND) begin
            if (reveal_d) begin
                tmo_d = TMO_RELOAD;
            end else if (tmo_q == '0) begin
                timeout_d = 1'b1;
                player_d  = ~player_q;
                tmo_d     = TMO_RELOAD;
                if (state_q == S_SECOND) begin
                    hide_d  = 1'b1;
                    idx_b_d = idx_a_q;
                    state_d = S_FIRST;
                end
            end else begin
                tmo_d = tmo_q - TO_W'(1);
            end
        end else if (state_d == S_FIRST) begin
            tmo_d = TMO_RELOAD;
        end
`endif

        busy_d   = (state_d == S_SHOW) || (state_d == S_RESOLVE);
        finish_d = (state_d == S_DONE);
        winner_d = 2'b00;
        if (finish_d) begin
            if (score0_d > score1_d)      winner_d = 2'b01;
            else if (score1_d > score0_d) winner_d = 2'b10;
            else                          winner_d = 2'b11;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_FIRST;
            idx_a_q      <= '0;
            idx_b_q      <= '0;
            reveal_idx_q <= '0;
            label_a_q    <= '0;
            label_b_q    <= '0;
            score0_q     <= '0;
            score1_q     <= '0;
            timer_q      <= '0;
            pairs_left_q <= PL_W'(N_PAIRS);
            player_q     <= 1'b0;
            reveal_q     <= 1'b0;
            hide_q       <= 1'b0;
            par_q        <= 1'b0;
            busy_q       <= 1'b0;
            finish_q     <= 1'b0;
            winner_q     <= 2'b00;
`ifdef TURN_TIMEOUT_EN
            tmo_q        <= TMO_RELOAD;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            idx_a_q      <= idx_a_d;
            idx_b_q      <= idx_b_d;
            reveal_idx_q <= reveal_idx_d;
            label_a_q    <= label_a_d;
            label_b_q    <= label_b_d;
            score0_q     <= score0_d;
            score1_q     <= score1_d;
            timer_q      <= timer_d;
            pairs_left_q <= pairs_left_d;
            player_q     <= player_d;
            reveal_q     <= reveal_d;
            hide_q       <= hide_d;
            par_q        <= par_d;
            busy_q       <= busy_d;
            finish_q     <= finish_d;
            winner_q     <= winner_d;
`ifdef TURN_TIMEOUT_EN
            tmo_q        <= tmo_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    assign reveal     = reveal_q;
    assign reveal_idx = reveal_idx_q;
    assign hide       = hide_q;
    assign par        = par_q;
    assign idx_a      = idx_a_q;
    assign idx_b      = idx_b_q;
    assign player     = player_q;
    assign score0     = score0_q;
    assign score1     = score1_q;
    assign busy       = busy_q;
    assign finish     = finish_q;
    assign winner     = winner_q;
`ifdef TURN_TIMEOUT_EN
    assign timeout    = timeout_q;
`endif

endmodule

// File: tb/tb_pair_judge.sv
// tb/tb_pair_judge.sv - scoreboard bench for pair_judge with a behavioural card board
module tb_pair_judge;
    localparam int RC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       select = 1'b0;
    logic [3:0] cursor = 4'd0;
    logic [3:0] card_label;
    logic       card_hidden;
    logic       reveal, hide, par, player, busy, finish;
    logic [3:0] reveal_idx, idx_a, idx_b, score0, score1;
    logic [1:0] winner;

    logic [3:0] lab [16];
    logic       hid [16];
    assign card_label  = lab[cursor];
    assign card_hidden = hid[cursor];

    pair_judge #(.N_PAIRS(8), .REVEAL_CYCLES(RC), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .select(select), .cursor(cursor),
        .card_label(card_label), .card_hidden(card_hidden),
        .reveal(reveal), .reveal_idx(reveal_idx), .hide(hide), .par(par),
        .idx_a(idx_a), .idx_b(idx_b), .player(player),
        .score0(score0), .score1(score1), .busy(busy),
        .finish(finish), .winner(winner)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass = 0;
    logic [9:0] exp_q [$];
    logic [9:0] obs_q [$];
    logic       m_player;
    logic [3:0] m_s0, m_s1;
    int         m_left;

    // Board model plus event capture: {kind, a, b}, kind 1=reveal 2=par 3=hide.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) hid[i] <= 1'b1;
        end else begin
            if (reveal) begin
                obs_q.push_back({2'd1, reveal_idx, 4'd0});
                hid[reveal_idx] <= 1'b0;
            end
            if (par)  obs_q.push_back({2'd2, idx_a, idx_b});
            if (hide) begin
                obs_q.push_back({2'd3, idx_a, idx_b});
                hid[idx_a] <= 1'b1;
                hid[idx_b] <= 1'b1;
            end
        end
    end

    task automatic pick(input logic [3:0] cur);
        cursor = cur;
        select = 1'b1;
        @(negedge clk); #1;
        select = 1'b0;
    endtask

    task automatic wait_resolve(output int bc, output bit ok);
        int n = 0;
        bc = 0;
        while (n < 20 && !(par || hide)) begin
            if (busy) bc++;
            @(negedge clk); #1;
            n++;
        end
        ok = par || hide;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        rst = 1'b1;
        m_player = 1'b0; m_s0 = 4'd0; m_s1 = 4'd0; m_left = 8;
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic play_turn(input logic [3:0] a, input logic [3:0] b);
        int   bc;
        bit   ok;
        logic match;
        logic [9:0] e, o;
        match = (lab[a] == lab[b]);
        exp_q.push_back({2'd1, a, 4'd0});
        exp_q.push_back({2'd1, b, 4'd0});
        exp_q.push_back({match ? 2'd2 : 2'd3, a, b});
        pick(a);
        pick(b);
        wait_resolve(bc, ok);
        if (match) begin
            if (!m_player) m_s0++; else m_s1++;
            m_left--;
        end else begin
            m_player = ~m_player;
        end
        n_checks++; if (!ok) $display("FAIL turn_timeout a=%0d b=%0d no par/hide", a, b); else n_pass++;
        n_checks++; if (bc != RC + 1) $display("FAIL turn_busy got %0d want %0d", bc, RC + 1); else n_pass++;
        n_checks++; if (idx_a !== a) $display("FAIL turn_idx_a got %0d want %0d", idx_a, a); else n_pass++;
        n_checks++; if (idx_b !== b) $display("FAIL turn_idx_b got %0d want %0d", idx_b, b); else n_pass++;
        n_checks++; if (player !== m_player) $display("FAIL turn_player got %0d want %0d", player, m_player); else n_pass++;
        n_checks++; if (score0 !== m_s0) $display("FAIL turn_score0 got %0d want %0d", score0, m_s0); else n_pass++;
        n_checks++; if (score1 !== m_s1) $display("FAIL turn_score1 got %0d want %0d", score1, m_s1); else n_pass++;
        n_checks++; if (finish !== (m_left == 0)) $display("FAIL turn_finish got %0d want %0d", finish, m_left == 0); else n_pass++;
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL turn_events got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++; if (o !== e) $display("FAIL turn_event got %h want %h", o, e); else n_pass++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        n_checks++; if ({reveal, hide, par, busy, finish} !== 5'b0) $display("FAIL reset_flags got %b want 00000", {reveal, hide, par, busy, finish}); else n_pass++;
        n_checks++; if ({idx_a, idx_b, reveal_idx} !== 12'h0) $display("FAIL reset_idx got %h want 000", {idx_a, idx_b, reveal_idx}); else n_pass++;
        n_checks++; if ({player, score0, score1, winner} !== 11'h0) $display("FAIL reset_score got %h want 000", {player, score0, score1, winner}); else n_pass++;
        do_reset();
    endtask

    task automatic test_match();
        play_turn(4'd0, 4'd13);
    endtask

    task automatic test_mismatch();
        play_turn(4'd1, 4'd2);
    endtask

    task automatic test_ignored();
        int   bc;
        bit   ok;
        logic [9:0] e, o;
        exp_q.push_back({2'd1, 4'd5, 4'd0});
        pick(4'd5);
        pick(4'd5);
        pick(4'd0);
        @(negedge clk); #1;
        n_checks++; if (obs_q.size() != 1) $display("FAIL ign_second got %0d events want 1", obs_q.size()); else n_pass++;
        n_checks++; if (idx_a !== 4'd5 || reveal_idx !== 4'd5 || busy !== 1'b0) $display("FAIL ign_state got a=%0d r=%0d busy=%0d want 5 5 0", idx_a, reveal_idx, busy); else n_pass++;
        exp_q.push_back({2'd1, 4'd6, 4'd0});
        exp_q.push_back({2'd2, 4'd5, 4'd6});
        pick(4'd6);
        pick(4'd7);
        wait_resolve(bc, ok);
        m_s1++; m_left--;
        n_checks++; if (!ok) $display("FAIL ign_timeout no par/hide"); else n_pass++;
        n_checks++; if (idx_b !== 4'd6) $display("FAIL ign_idx_b got %0d want 6", idx_b); else n_pass++;
        n_checks++; if (score1 !== m_s1) $display("FAIL ign_score1 got %0d want %0d", score1, m_s1); else n_pass++;
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL ign_events got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++; if (o !== e) $display("FAIL ign_event got %h want %h", o, e); else n_pass++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        pick(4'd1);
        pick(4'd3);
        @(negedge clk); #1;
        n_checks++; if (busy !== 1'b1) $display("FAIL rmid_busy got %0d want 1", busy); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if ({busy, player, score0, score1} !== 10'h0) $display("FAIL rmid_async got %h want 000", {busy, player, score0, score1}); else n_pass++;
        @(negedge clk); #1;
        rst = 1'b1;
        m_player = 1'b0; m_s0 = 4'd0; m_s1 = 4'd0; m_left = 8;
        obs_q.delete();
        repeat (10) @(negedge clk);
        #1;
        n_checks++; if (obs_q.size() != 0) $display("FAIL rmid_pulse got %0d events want 0", obs_q.size()); else n_pass++;
        obs_q.delete();
        play_turn(4'd1, 4'd3);
    endtask

    task automatic test_game(input bit tie);
        logic [1:0] w;
        do_reset();
        play_turn(4'd0, 4'd13); play_turn(4'd1, 4'd3); play_turn(4'd2, 4'd4); play_turn(4'd5, 4'd6);
        if (tie) begin
            play_turn(4'd7, 4'd9);
            play_turn(4'd7, 4'd8);
        end else begin
            play_turn(4'd7, 4'd8);
            play_turn(4'd9, 4'd11);
        end
        play_turn(4'd9, 4'd10); play_turn(4'd11, 4'd12); play_turn(4'd14, 4'd15);
        w = (m_s0 > m_s1) ? 2'b01 : (m_s1 > m_s0) ? 2'b10 : 2'b11;
        n_checks++; if (winner !== w) $display("FAIL game_winner got %b want %b", winner, w); else n_pass++;
        n_checks++; if (w !== (tie ? 2'b11 : 2'b01)) $display("FAIL game_model got %b want %b", w, tie ? 2'b11 : 2'b01); else n_pass++;
        pick(4'd0);
        pick(4'd15);
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (obs_q.size() != 0) $display("FAIL game_after got %0d events want 0", obs_q.size()); else n_pass++;
        n_checks++; if (finish !== 1'b1 || busy !== 1'b0 || winner !== w) $display("FAIL game_hold got f=%0d b=%0d w=%b want 1 0 %b", finish, busy, winner, w); else n_pass++;
        obs_q.delete();
    endtask

    initial begin
        lab = '{4'd1, 4'd2, 4'd3, 4'd2, 4'd3, 4'd4, 4'd4, 4'd5,
                4'd5, 4'd6, 4'd6, 4'd7, 4'd7, 4'd1, 4'd0, 4'd0};
        test_reset();
        test_match();
        test_mismatch();
        test_ignored();
        test_reset_mid();
        test_game(1'b0);
        test_game(1'b1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
